// File: rtl/learning_pkg.sv
// Shared definitions for the learning-mode sequencer.
//   - state_t     : sequencer FSM states
//   - NOTE_END    : song-ROM code that terminates a song
//   - note_to_key : maps a non-zero note code to its key index
//   - DEF_*       : default key count and note-index width
package learning_pkg;

   localparam int DEF_NUM_KEYS   = 7;
   localparam int DEF_SONG_LEN_W = 6;
   localparam int NOTE_END       = 0;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_LOAD,
      ST_SHOW,
      ST_DONE
   } state_t;

   // Note code k (k >= 1) lights key k-1.
   function automatic int unsigned note_to_key(input int unsigned code);
      return code - 1;
   endfunction

endpackage

// File: rtl/learning_sequencer_rise_detect.sv
// Rising-edge detector over a W-bit level bus.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset
//   in_i   : level inputs
//   rise_o : one-cycle pulse per bit that went 0 -> 1
// The previous-sample register resets to all-ones so a level that is
// already high when reset releases never reports an edge.
module rise_detect #(
   parameter int W = 1
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] in_i,
   output logic [W-1:0] rise_o
);

   logic [W-1:0] prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) prev_q <= '1;
      else       prev_q <= in_i;
   end

   assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/learning_sequencer.sv
// Learning-mode engine: song paging, note-by-note stepping through a
// song held in an external registered ROM, press judging and scoring.
//   clk, rst     : clock, synchronous active-high reset
//   key_in       : note keys (level, already synchronised)
//   l_r_page     : [1] previous song, [0] next song (level)
//   start        : rising edge starts / restarts the selected song
//   strict       : 1 = advance only on the correct key
//   rom_addr     : {song_id, note_idx} to the song ROM
//   rom_data     : note code, valid one cycle after rom_addr
//   song_id      : selected song
//   light        : one-hot expected key while waiting for a press
//   tone         : code of lowest held key (0 = silent), registered
//   hits, misses : saturating scores
//   done         : song finished
//   dbg_state_o  : current FSM state for observation
// ROM contract: the address is driven from registers during FETCH, the
// ROM registers its output on that edge, and the code is captured at
// the end of LOAD. No handshake; the latency is fixed at one cycle.
module learning_sequencer
   import learning_pkg::*;
#(
   parameter int NUM_KEYS   = DEF_NUM_KEYS,
   parameter int NUM_SONGS  = 8,
   parameter int SONG_LEN_W = DEF_SONG_LEN_W,
   parameter int SONG_ID_W  = $clog2(NUM_SONGS),
   parameter int NOTE_W     = $clog2(NUM_KEYS + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_KEYS-1:0]             key_in,
   input  logic [1:0]                      l_r_page,
   input  logic                            start,
   input  logic                            strict,
   output logic [SONG_ID_W+SONG_LEN_W-1:0] rom_addr,
   input  logic [NOTE_W-1:0]               rom_data,
   output logic [SONG_ID_W-1:0]            song_id,
   output logic [NUM_KEYS-1:0]             light,
   output logic [NOTE_W-1:0]               tone,
   output logic [7:0]                      hits,
   output logic [7:0]                      misses,
   output logic                            done,
   output state_t                          dbg_state_o
);

   logic [NUM_KEYS-1:0] key_rise;
   logic [1:0]          page_rise;
   logic                start_rise;

   rise_detect #(.W(NUM_KEYS)) u_key_rise (
      .clk_i (clk), .rst_i (rst), .in_i (key_in), .rise_o (key_rise)
   );
   rise_detect #(.W(2)) u_page_rise (
      .clk_i (clk), .rst_i (rst), .in_i (l_r_page), .rise_o (page_rise)
   );
   rise_detect #(.W(1)) u_start_rise (
      .clk_i (clk), .rst_i (rst), .in_i (start), .rise_o (start_rise)
   );

   state_t                state_q,    state_d;
   logic [SONG_ID_W-1:0]  song_id_q,  song_id_d;
   logic [SONG_LEN_W-1:0] note_idx_q, note_idx_d;
   logic [NOTE_W-1:0]     expected_q, expected_d;
   logic [NUM_KEYS-1:0]   light_q,    light_d;
   logic [NOTE_W-1:0]     tone_q,     tone_d;
   logic [7:0]            hits_q,     hits_d;
   logic [7:0]            misses_q,   misses_d;
   logic                  done_q,     done_d;

   logic [NOTE_W-1:0]     load_key;
   logic                  hit;
   logic                  restart;
   logic                  advance;

   assign load_key = NOTE_W'(note_to_key(32'(rom_data)));
   // A hit needs exactly the expected bit and nothing else rising.
   assign hit      = (key_rise == (NUM_KEYS'(1) << expected_q));

   // Lowest-index held key wins; scanning downward lets it overwrite.
   always_comb begin
      tone_d = '0;
      for (int i = NUM_KEYS - 1; i >= 0; i--) begin
         if (key_in[i]) tone_d = NOTE_W'(i + 1);
      end
   end

   always_comb begin
      state_d    = state_q;
      song_id_d  = song_id_q;
      note_idx_d = note_idx_q;
      expected_d = expected_q;
      light_d    = light_q;
      hits_d     = hits_q;
      misses_d   = misses_q;
      done_d     = done_q;
      restart    = 1'b0;
      advance    = 1'b0;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start_rise) begin
               restart = 1'b1;
            end else if (page_rise != 2'b00) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
               if (page_rise == 2'b01) begin
                  song_id_d = (song_id_q == SONG_ID_W'(NUM_SONGS - 1)) ? '0 : song_id_q + 1'b1;
               end else if (page_rise == 2'b10) begin
                  song_id_d = (song_id_q == '0) ? SONG_ID_W'(NUM_SONGS - 1) : song_id_q - 1'b1;
               end
            end
         end
         ST_FETCH: state_d = ST_LOAD;
         ST_LOAD: begin
            if (rom_data == NOTE_W'(NOTE_END)) begin
               state_d = ST_DONE;
               done_d  = 1'b1;
            end else begin
               expected_d = load_key;
               light_d    = NUM_KEYS'(1) << load_key;
               state_d    = ST_SHOW;
            end
         end
         ST_SHOW: begin
            // start beats a simultaneous key rise; that key is not judged.
            if (start_rise) begin
               restart = 1'b1;
            end else if (key_rise != '0) begin
               if (hit) begin
                  if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
                  advance = 1'b1;
               end else begin
                  if (misses_q != 8'hFF) misses_d = misses_q + 8'd1;
                  advance = !strict;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (restart) begin
         note_idx_d = '0;
         hits_d     = '0;
         misses_d   = '0;
         done_d     = 1'b0;
         light_d    = '0;
         state_d    = ST_FETCH;
      end

      if (advance) begin
         light_d = '0;
         // An unterminated song stops at the last index rather than wrapping.
         if (&note_idx_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
         end else begin
            note_idx_d = note_idx_q + 1'b1;
            state_d    = ST_FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         song_id_q  <= '0;
         note_idx_q <= '0;
         expected_q <= '0;
         light_q    <= '0;
         tone_q     <= '0;
         hits_q     <= '0;
         misses_q   <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         song_id_q  <= song_id_d;
         note_idx_q <= note_idx_d;
         expected_q <= expected_d;
         light_q    <= light_d;
         tone_q     <= tone_d;
         hits_q     <= hits_d;
         misses_q   <= misses_d;
         done_q     <= done_d;
      end
   end

   assign rom_addr    = {song_id_q, note_idx_q};
   assign song_id     = song_id_q;
   assign light       = light_q;
   assign tone        = tone_q;
   assign hits        = hits_q;
   assign misses      = misses_q;
   assign done        = done_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_learning_sequencer.sv
// Bench for learning_sequencer: a default-size instance (a) and a
// 4-note-song instance (b), each fed by a registered song ROM model.
module tb_learning_sequencer;
   import learning_pkg::*;

   localparam int NK  = 7;
   localparam int NS  = 8;
   localparam int LW  = 6;
   localparam int LWB = 2;
   localparam int SW  = 3;
   localparam int NW  = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- instance a ----------------
   logic [NK-1:0]    key_a;
   logic [1:0]       page_a;
   logic             start_a, strict_a;
   logic [SW+LW-1:0] addr_a;
   logic [NW-1:0]    data_a;
   logic [SW-1:0]    song_a;
   logic [NK-1:0]    light_a;
   logic [NW-1:0]    tone_a;
   logic [7:0]       hits_a, misses_a;
   logic             done_a;
   state_t           st_a;
   logic [NW-1:0]    rom_a [0:(1<<(SW+LW))-1];

   learning_sequencer #(.NUM_KEYS(NK), .NUM_SONGS(NS), .SONG_LEN_W(LW)) dut_a (
      .clk(clk), .rst(rst), .key_in(key_a), .l_r_page(page_a), .start(start_a),
      .strict(strict_a), .rom_addr(addr_a), .rom_data(data_a), .song_id(song_a),
      .light(light_a), .tone(tone_a), .hits(hits_a), .misses(misses_a),
      .done(done_a), .dbg_state_o(st_a)
   );

   // ---------------- instance b ----------------
   logic [NK-1:0]     key_b;
   logic              start_b, strict_b;
   logic [SW+LWB-1:0] addr_b;
   logic [NW-1:0]     data_b;
   logic [SW-1:0]     song_b;
   logic [NK-1:0]     light_b;
   logic [NW-1:0]     tone_b;
   logic [7:0]        hits_b, misses_b;
   logic              done_b;
   state_t            st_b;
   logic [NW-1:0]     rom_b [0:(1<<(SW+LWB))-1];

   learning_sequencer #(.NUM_KEYS(NK), .NUM_SONGS(NS), .SONG_LEN_W(LWB)) dut_b (
      .clk(clk), .rst(rst), .key_in(key_b), .l_r_page(2'b00), .start(start_b),
      .strict(strict_b), .rom_addr(addr_b), .rom_data(data_b), .song_id(song_b),
      .light(light_b), .tone(tone_b), .hits(hits_b), .misses(misses_b),
      .done(done_b), .dbg_state_o(st_b)
   );

   // Registered song ROMs: data follows the address by one clock.
   always @(posedge clk) begin
      data_a <= rom_a[addr_a];
      data_b <= rom_b[addr_b];
   end

   // Watches instance b for the note index ever falling back to 0.
   logic             watch_b;
   logic             wrap_seen;
   logic [LWB-1:0]   last_idx_b;
   always @(negedge clk) begin
      if (!watch_b) begin
         wrap_seen  = 1'b0;
         last_idx_b = '0;
      end else begin
         if (addr_b[LWB-1:0] == '0 && last_idx_b != '0) wrap_seen = 1'b1;
         last_idx_b = addr_b[LWB-1:0];
      end
   end

   // ---------------- model state ----------------
   logic [SW-1:0]   cur_sid;
   logic [NW-1:0]   song_q[$];
   logic [NK-1:0]   exp_q[$];
   logic [NK-1:0]   light_e;

   // ---------------- driver tasks ----------------
   task automatic write_song_a();
      for (int i = 0; i < (1 << LW); i++) rom_a[{cur_sid, LW'(i)}] = NW'($urandom_range(1, NK));
      for (int i = 0; i < song_q.size(); i++) rom_a[{cur_sid, LW'(i)}] = song_q[i];
      if (song_q.size() < (1 << LW)) rom_a[{cur_sid, LW'(song_q.size())}] = '0;
   endtask

   // Press pattern; light_o is sampled just after the judging edge,
   // and the task returns two edges later when the next note is lit.
   task automatic press_a(input logic [NK-1:0] pat, output logic [NK-1:0] light_o);
      @(negedge clk) key_a = pat;
      @(negedge clk) light_o = light_a; key_a = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic press_b(input logic [NK-1:0] pat);
      @(negedge clk) key_b = pat;
      @(negedge clk) key_b = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic start_pulse_a();
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic page_pulse_a(input logic [1:0] p);
      @(negedge clk) page_a = p;
      @(negedge clk) page_a = 2'b00;
   endtask

   function automatic logic [NK-1:0] key_of(input logic [NW-1:0] code);
      logic [NK-1:0] one;
      one = 1;
      return one << (int'(code) - 1);
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1; key_a = 7'h01; page_a = 2'b01; start_a = 1'b0; strict_a = 1'b1;
      key_b = '0; start_b = 1'b0; strict_b = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (song_a !== 3'd0) begin errors++; $display("FAIL reset_song_held: got %0d want 0", song_a); end
      checks++; if (st_a !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", st_a, ST_IDLE); end
      checks++; if (tone_a !== 3'd1) begin errors++; $display("FAIL reset_tone_held: got %0d want 1", tone_a); end
      key_a = '0; page_a = 2'b00;
      repeat (3) @(negedge clk);
      checks++; if (song_a !== 3'd0) begin errors++; $display("FAIL reset_song: got %0d want 0", song_a); end
      checks++; if (hits_a !== 8'd0 || misses_a !== 8'd0) begin errors++; $display("FAIL reset_scores: got %0d/%0d want 0/0", hits_a, misses_a); end
      checks++; if (light_a !== 7'd0) begin errors++; $display("FAIL reset_light: got %b want 0", light_a); end
      checks++; if (done_a !== 1'b0 || addr_a !== '0) begin errors++; $display("FAIL reset_done_addr: got %0d/%0h want 0/0", done_a, addr_a); end
      cur_sid = '0;
   endtask

   task automatic test_tone();
      logic [NK-1:0] r;
      logic [NW-1:0] exp_t;
      for (int n = 0; n < 16; n++) begin
         r = NK'($urandom_range(0, (1 << NK) - 1));
         exp_t = '0;
         for (int i = 0; i < NK; i++) if (r[i]) begin exp_t = NW'(i + 1); break; end
         @(negedge clk) key_a = r;
         @(negedge clk);
         checks++; if (tone_a !== exp_t) begin errors++; $display("FAIL tone: keys %b got %0d want %0d", r, tone_a, exp_t); end
      end
      key_a = '0;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_paging();
      logic [1:0] p;
      page_pulse_a(2'b10);
      checks++; if (song_a !== 3'(NS - 1)) begin errors++; $display("FAIL page_prev_wrap: got %0d want %0d", song_a, NS - 1); end
      page_pulse_a(2'b01);
      checks++; if (song_a !== 3'd0) begin errors++; $display("FAIL page_next_wrap: got %0d want 0", song_a); end
      page_pulse_a(2'b11);
      checks++; if (song_a !== 3'd0) begin errors++; $display("FAIL page_both: got %0d want 0", song_a); end
      for (int n = 0; n < 12; n++) begin
         p = 2'($urandom_range(1, 3));
         if (p == 2'b01) cur_sid = 3'((int'(cur_sid) + 1) % NS);
         else if (p == 2'b10) cur_sid = 3'((int'(cur_sid) + NS - 1) % NS);
         page_pulse_a(p);
         checks++; if (song_a !== cur_sid) begin errors++; $display("FAIL page_rand: got %0d want %0d", song_a, cur_sid); end
      end
   endtask

   task automatic test_song_strict();
      song_q = '{3'd3, 3'd5};
      write_song_a();
      strict_a = 1'b1;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      checks++; if (st_a !== ST_FETCH || light_a !== 7'd0) begin errors++; $display("FAIL start_fetch: got st %0d light %b want %0d 0", st_a, light_a, ST_FETCH); end
      @(negedge clk);
      checks++; if (light_a !== 7'd0) begin errors++; $display("FAIL start_load_light: got %b want 0", light_a); end
      @(negedge clk);
      checks++; if (light_a !== 7'b0000100) begin errors++; $display("FAIL first_light: got %b want 0000100", light_a); end
      press_a(7'b0000100, light_e);
      checks++; if (light_e !== 7'd0) begin errors++; $display("FAIL hit_light_drop: got %b want 0", light_e); end
      checks++; if (hits_a !== 8'd1 || light_a !== 7'b0010000) begin errors++; $display("FAIL hit_next: got hits %0d light %b want 1 0010000", hits_a, light_a); end
      press_a(7'b0000001, light_e);
      checks++; if (misses_a !== 8'd1 || light_a !== 7'b0010000 || light_e !== 7'b0010000) begin errors++; $display("FAIL strict_miss: got misses %0d light %b/%b want 1 0010000", misses_a, light_e, light_a); end
      press_a(7'b0010000, light_e);
      checks++; if (done_a !== 1'b1 || hits_a !== 8'd2 || light_a !== 7'd0) begin errors++; $display("FAIL strict_done: got done %0d hits %0d light %b want 1 2 0", done_a, hits_a, light_a); end
      // paging out of DONE
      page_pulse_a(2'b01);
      checks++; if (done_a !== 1'b0 || st_a !== ST_IDLE || song_a !== 3'(int'(cur_sid) + 1)) begin errors++; $display("FAIL done_page: got done %0d st %0d song %0d want 0 %0d %0d", done_a, st_a, song_a, ST_IDLE, int'(cur_sid) + 1); end
      page_pulse_a(2'b10);
   endtask

   task automatic test_song_loose();
      strict_a = 1'b0;
      start_pulse_a();
      press_a(7'b1000000, light_e);
      checks++; if (misses_a !== 8'd1 || light_a !== 7'b0010000) begin errors++; $display("FAIL loose_adv: got misses %0d light %b want 1 0010000", misses_a, light_a); end
      press_a(7'b1000000, light_e);
      checks++; if (misses_a !== 8'd2 || hits_a !== 8'd0 || done_a !== 1'b1) begin errors++; $display("FAIL loose_done: got %0d/%0d/%0d want 2/0/1", misses_a, hits_a, done_a); end
   endtask

   task automatic test_restart();
      strict_a = 1'b1;
      start_pulse_a();
      press_a(7'b0000100, light_e);
      press_a(7'b0000001, light_e);
      @(negedge clk) begin start_a = 1'b1; key_a = 7'b0010000; end
      @(negedge clk);
      checks++; if (hits_a !== 8'd0 || misses_a !== 8'd0 || light_a !== 7'd0) begin errors++; $display("FAIL restart_clear: got %0d/%0d light %b want 0/0 0", hits_a, misses_a, light_a); end
      start_a = 1'b0; key_a = '0;
      repeat (2) @(negedge clk);
      checks++; if (light_a !== 7'b0000100 || addr_a !== {cur_sid, 6'd0}) begin errors++; $display("FAIL restart_relit: got light %b addr %0h want 0000100 %0h", light_a, addr_a, {cur_sid, 6'd0}); end
   endtask

   task automatic test_unterminated();
      logic [NW-1:0] notes[4];
      notes = '{3'd2, 3'd7, 3'd1, 3'd4};
      for (int i = 0; i < 4; i++) rom_b[i] = notes[i];
      strict_b = 1'b1;
      watch_b = 1'b1;
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         checks++; if (light_b !== key_of(notes[i]) || done_b !== 1'b0) begin errors++; $display("FAIL unterm_note%0d: got light %b done %0d want %b 0", i, light_b, done_b, key_of(notes[i])); end
         press_b(key_of(notes[i]));
      end
      repeat (6) @(negedge clk);
      checks++; if (done_b !== 1'b1 || hits_b !== 8'd4) begin errors++; $display("FAIL unterm_done: got done %0d hits %0d want 1 4", done_b, hits_b); end
      checks++; if (wrap_seen !== 1'b0 || addr_b !== 5'd3) begin errors++; $display("FAIL unterm_nowrap: got wrap %0d addr %0h want 0 3", wrap_seen, addr_b); end
      watch_b = 1'b0;
   endtask

   task automatic test_random();
      logic [NK-1:0] pat, exp_light;
      int idx, m_hits, m_miss, len, k1;
      bit m_done, adv;
      for (int t = 0; t < 6; t++) begin
         len = $urandom_range(1, 8);
         song_q.delete();
         for (int i = 0; i < len; i++) song_q.push_back(NW'($urandom_range(1, NK)));
         write_song_a();
         strict_a = 1'($urandom_range(0, 1));
         idx = 0; m_hits = 0; m_miss = 0; m_done = 0;
         start_pulse_a();
         checks++; if (light_a !== key_of(song_q[0])) begin errors++; $display("FAIL rand_first: got %b want %b", light_a, key_of(song_q[0])); end
         for (int n = 0; n < 20 && !m_done; n++) begin
            k1 = $urandom_range(0, 9);
            if (k1 < 6) pat = key_of(song_q[idx]);
            else begin
               pat = key_of(NW'($urandom_range(1, NK)));
               if (k1 >= 8) pat = pat | key_of(NW'($urandom_range(1, NK)));
            end
            // judge exactly as the rules state: only the lone expected key is a hit
            if (pat == key_of(song_q[idx])) begin
               m_hits = (m_hits < 255) ? m_hits + 1 : 255; adv = 1;
            end else begin
               m_miss = (m_miss < 255) ? m_miss + 1 : 255; adv = !strict_a;
            end
            if (adv) begin
               if (idx == (1 << LW) - 1) m_done = 1;
               else begin idx++; if (idx >= song_q.size()) m_done = 1; end
            end
            exp_q.push_back(m_done ? '0 : key_of(song_q[idx]));
            press_a(pat, light_e);
            exp_light = exp_q.pop_front();
            checks++;
            if (light_a !== exp_light || hits_a !== 8'(m_hits) || misses_a !== 8'(m_miss) || done_a !== m_done) begin
               errors++;
               $display("FAIL rand_step: pat %b got light %b h %0d m %0d d %0d want %b %0d %0d %0d",
                        pat, light_a, hits_a, misses_a, done_a, exp_light, m_hits, m_miss, m_done);
            end
         end
      end
   endtask

   task automatic test_saturation();
      song_q = '{3'd1};
      write_song_a();
      strict_a = 1'b1;
      start_pulse_a();
      for (int n = 0; n < 260; n++) press_a(7'b1000000, light_e);
      checks++; if (misses_a !== 8'd255 || hits_a !== 8'd0 || light_a !== 7'b0000001) begin errors++; $display("FAIL miss_saturate: got %0d/%0d light %b want 255/0 0000001", misses_a, hits_a, light_a); end
   endtask

   task automatic test_reset_mid_song();
      page_pulse_a(2'b00);
      start_pulse_a();
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      checks++; if (st_a !== ST_IDLE || light_a !== 7'd0 || hits_a !== 8'd0 || misses_a !== 8'd0 || addr_a !== '0) begin
         errors++; $display("FAIL mid_reset: got st %0d light %b h %0d m %0d addr %0h want idle 0 0 0 0", st_a, light_a, hits_a, misses_a, addr_a);
      end
      cur_sid = '0;
   endtask

   initial begin
      watch_b = 1'b0;
      for (int i = 0; i < (1 << (SW + LW)); i++) rom_a[i] = '0;
      for (int i = 0; i < (1 << (SW + LWB)); i++) rom_b[i] = '0;
      test_reset();
      test_tone();
      test_paging();
      test_song_strict();
      test_song_loose();
      test_restart();
      test_unterminated();
      test_random();
      test_saturation();
      test_reset_mid_song();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/learning_sequencer.md
# learning_sequencer

Parametrised second-generation learning-mode engine for the keyboard. It selects a song with edge-detected, wrap-around paging and steps through that song note by note. For each note it lights the expected key, waits for the player's press, judges it, and keeps hit/miss scores. Song notes come from an external registered song ROM; `tone` feeds the existing speaker tone generator.

## Interface
- `NUM_KEYS`, 7: note keys, one light per key.
- `NUM_SONGS`, 8: selectable songs, ≥2.
- `SONG_LEN_W`, 6: note-index width; max song length 2^SONG_LEN_W.
- `SONG_ID_W`, $clog2(NUM_SONGS): song-id width.
- `NOTE_W`, $clog2(NUM_KEYS+1): note-code width.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `key_in`  in  NUM_KEYS  note keys, level, debounced/synchronised upstream.
- `l_r_page`  in  2  paging; [1]=previous song, [0]=next song, level.
- `start`  in  1  level; rising edge starts or restarts the selected song.
- `strict`  in  1  1: advance only on the correct key; 0: advance on any key.
- `rom_addr`  out  SONG_ID_W+SONG_LEN_W  {song_id, note_idx}.
- `rom_data`  in  NOTE_W  note code, valid one cycle after `rom_addr`.
  - 0 = end of song.
  - k = key k-1.
- `song_id`  out  SONG_ID_W  selected song.
- `light`  out  NUM_KEYS  one-hot expected key; 0 when not in SHOW.
- `tone`  out  NOTE_W  code of the lowest-index held key; 0 = silent.
- `hits`, `misses`  out  8 each  saturating score counters.
- `done`  out  1  song finished.

## Operation
- Rising edges are detected against registered previous samples of `key_in`, `l_r_page` and `start`.
  - All previous-sample registers reset to all-ones, so a level held through reset is never an edge.
- States:
  - IDLE: paging active.
  - FETCH: drive `rom_addr`.
  - LOAD: capture `rom_data`.
  - SHOW: light the expected key, wait for a press.
  - DONE: song finished.
- Paging (IDLE and DONE only; ignored in other states):
  - Rise on [0]: `song_id` +1, wrapping NUM_SONGS-1→0.
  - Rise on [1]: `song_id` −1, wrapping 0→NUM_SONGS-1.
  - Both rise in the same cycle: no change.
  - Paging in DONE returns to IDLE and clears `done`.
- `start` rise in IDLE, DONE or SHOW:
  - Clears `note_idx`, `hits`, `misses` and `done`.
  - Goes to FETCH. This is a restart mid-song.
- FETCH→LOAD unconditionally.
- LOAD:
  - Code 0 → DONE.
  - Otherwise register `expected = code-1` → SHOW.
- SHOW, on any `key_in` rise:
  - Exactly one bit rises and it equals `expected`: hit.
  - Otherwise (wrong key, or several bits rise at once): miss.
  - Hit: `hits`+1; advance.
  - Miss with `strict=1`: `misses`+1; stay in SHOW with the same note.
  - Miss with `strict=0`: `misses`+1; advance.
  - No rise: hold.
- Advance:
  - `note_idx`+1 → FETCH.
  - If `note_idx` is already all-ones, go to DONE instead. An unterminated song never wraps.
- `start` rise and key rise in the same SHOW cycle: `start` wins; the key is not judged.
- Counters saturate at 255.
- `tone` is combinational-free registered output, updated every cycle in every state, independent of judging.

## Timing
- Reset values:
  - State IDLE.
  - `song_id`, `note_idx`, `rom_addr`, `light`, `tone`, `hits`, `misses`: 0.
  - `done`: 0.
- `rst` mid-song returns to these values at the next edge; any pending ROM read is discarded.
- `start` rise sampled at edge E:
  - FETCH is entered at E.
  - LOAD at E+1.
  - `light` shows the note at E+2.
- In SHOW, a press rise sampled at edge E:
  - Counters update at E.
  - `light` drops to 0 at E.
  - The next note lights at E+2.
- `song_id` updates on the edge that samples the paging rise.
- `done` asserts on the edge that leaves LOAD or SHOW for DONE.
- `tone` lags `key_in` by one cycle.

## Structure
- Shared package `learning_pkg` holds:
  - State enum.
  - `NOTE_END = 0`.
  - Note-code-to-key helper.
  - Default `NUM_KEYS` and `SONG_LEN_W`.
- Sub-module `rise_detect #(W)`:
  - One register stage with reset value all-ones.
  - Output = `in & ~prev`.
  - Instantiated three times: keys, paging, start.

## Test plan
- Reset with `key_in=7'h01` held and `l_r_page=2'b01` held → no edge; `song_id=0`, `hits=0`, `light=0` after release and re-idle.
- `song_id=0`, one [1] pulse → `song_id=NUM_SONGS-1`; then one [0] pulse → 0; both bits together → unchanged.
- Song ROM {3,5,0} with `strict=1`:
  - Start → `light=7'b0000100` two cycles later.
  - Press key 2 → `hits=1`; `light=7'b0010000`.
  - Press key 0 → `misses=1`, `light` unchanged.
  - Press key 4 → `done=1`, `hits=2`.
- Same ROM with `strict=0`: press key 6 then key 6 → `misses=2`, `hits=0`, `done=1`.
- SONG_LEN_W=2, ROM with no terminator (4 non-zero notes), all hit → `done=1` after the 4th press; `rom_addr` never returns to note 0.
- Mid-song `start` rise coincident with a key rise → `hits`/`misses` = 0, `note_idx=0`, first note relit.
